// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and bubble control zeroing. Optional load-use detection: ID_EX_HAZARD_DETECT_EN.
module id_ex_skid_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 16,
  parameter int RA_W      = 5,
  parameter int CTRL_W    = 20,
  parameter int MEMRE_BIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rdata1,
  input  logic [XLEN-1:0]   in_rdata2,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pc_plus4,
  input  logic [PC_W-1:0]   in_dest_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RA_W-1:0]   out_rs1,
  output logic [RA_W-1:0]   out_rs2,
  output logic [RA_W-1:0]   out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rdata1,
  output logic [XLEN-1:0]   out_rdata2,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc_plus4,
  output logic [PC_W-1:0]   out_dest_pc,
  output logic              hazard_stall
);

  // Handshake: a bundle moves ID->stage when in_valid & in_ready, and
  // stage->EX when out_valid & out_ready, both sampled at the rising edge.
  localparam int BW = CTRL_W + 3*RA_W + 3*XLEN + 3*PC_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic [BW-1:0] in_bundle;

  logic              main_valid;
  logic              skid_valid;
  logic              hazard;
  logic              accept;
  logic              fire;

  logic [CTRL_W-1:0] m_ctrl;
  logic [RA_W-1:0]   m_rs1;
  logic [RA_W-1:0]   m_rs2;
  logic [RA_W-1:0]   m_rd;
  logic [XLEN-1:0]   m_imm;
  logic [XLEN-1:0]   m_rdata1;
  logic [XLEN-1:0]   m_rdata2;
  logic [PC_W-1:0]   m_pc;
  logic [PC_W-1:0]   m_pc_plus4;
  logic [PC_W-1:0]   m_dest_pc;

  assign in_bundle = {in_ctrl, in_rs1, in_rs2, in_rd, in_imm, in_rdata1,
                      in_rdata2, in_pc, in_pc_plus4, in_dest_pc};

  assign {m_ctrl, m_rs1, m_rs2, m_rd, m_imm, m_rdata1,
          m_rdata2, m_pc, m_pc_plus4, m_dest_pc} = main_q;

  // Valid bits are a direct decode of the registered state, so in_ready
  // never depends on out_ready.
  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_SKID);

`ifdef ID_EX_HAZARD_DETECT_EN
  assign hazard = main_valid & m_ctrl[MEMRE_BIT] & (m_rd != '0) & in_valid &
                  ((in_rs1 == m_rd) | (in_rs2 == m_rd));
`else
  logic unused_load_flag;
  assign unused_load_flag = m_ctrl[MEMRE_BIT];
  assign hazard           = 1'b0;
`endif

  assign in_ready     = ~skid_valid & ~hazard;
  assign hazard_stall = hazard;
  assign accept       = in_valid & in_ready;
  assign fire         = main_valid & out_ready;

  assign out_valid    = main_valid;
  assign out_ctrl     = main_valid ? m_ctrl : '0;
  assign out_rs1      = m_rs1;
  assign out_rs2      = m_rs2;
  assign out_rd       = m_rd;
  assign out_imm      = m_imm;
  assign out_rdata1   = m_rdata1;
  assign out_rdata2   = m_rdata2;
  assign out_pc       = m_pc;
  assign out_pc_plus4 = m_pc_plus4;
  assign out_dest_pc  = m_dest_pc;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload is left stale; only the valid state is cleared.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_bundle;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && fire) begin
            main_d = in_bundle;
          end else if (accept) begin
            skid_d  = in_bundle;
            state_d = ST_SKID;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_id_ex_skid_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 16;
  localparam int RA_W = 5;
  localparam int CTRL_W = 20;
  localparam int MEMRE_BIT = 2;
  localparam logic [CTRL_W-1:0] CT   = 20'h00011;
  localparam logic [CTRL_W-1:0] LOAD = 20'h00005;
  localparam logic [CTRL_W-1:0] ONES = 20'hFFFFF;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic HZ_EN = 1'b1;
`else
  localparam logic HZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, hazard_stall;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [RA_W-1:0] in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] in_imm, in_rdata1, in_rdata2, out_imm, out_rdata1, out_rdata2;
  logic [PC_W-1:0] in_pc, in_pc_plus4, in_dest_pc, out_pc, out_pc_plus4, out_dest_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] imm, rdata1, rdata2;
    logic [PC_W-1:0] pc, pc_plus4, dest_pc;
  } bundle_t;

  typedef struct {
    logic iv, ordy, fl;
    logic [PC_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic e_ov;
    logic [PC_W-1:0] e_pc;
    logic [CTRL_W-1:0] e_ctrl;
    logic e_ir;
  } vec_t;

  bundle_t exp_q[$];
  vec_t vecs[19];

  id_ex_skid_stage #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .CTRL_W(CTRL_W),
                     .MEMRE_BIT(MEMRE_BIT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_dest_pc(in_dest_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_dest_pc(out_dest_pc),
    .hazard_stall(hazard_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                       input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                       input logic [RA_W-1:0] rd);
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    in_pc       = pc;
    in_ctrl     = ctrl;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_imm      = {16'hA5A5, pc};
    in_rdata1   = {16'h1111, pc};
    in_rdata2   = {16'h2222, pc};
    in_pc_plus4 = pc + 16'd4;
    in_dest_pc  = pc + 16'h0100;
  endtask

  task automatic drive_random();
    in_valid    = ($urandom_range(0, 9) < 7);
    out_ready   = ($urandom_range(0, 9) < 6);
    flush       = ($urandom_range(0, 31) == 0);
    in_ctrl     = CTRL_W'($urandom);
    in_rs1      = RA_W'($urandom_range(0, 3));
    in_rs2      = RA_W'($urandom_range(0, 3));
    in_rd       = RA_W'($urandom_range(0, 3));
    in_imm      = $urandom;
    in_rdata1   = $urandom;
    in_rdata2   = $urandom;
    in_pc       = PC_W'($urandom);
    in_pc_plus4 = PC_W'($urandom);
    in_dest_pc  = PC_W'($urandom);
  endtask

  function automatic bundle_t cur_in();
    bundle_t b;
    b = '{ctrl: in_ctrl, rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm,
           rdata1: in_rdata1, rdata2: in_rdata2, pc: in_pc,
           pc_plus4: in_pc_plus4, dest_pc: in_dest_pc};
    return b;
  endfunction

  function automatic bundle_t cur_out();
    bundle_t b;
    b = '{ctrl: out_ctrl, rs1: out_rs1, rs2: out_rs2, rd: out_rd, imm: out_imm,
           rdata1: out_rdata1, rdata2: out_rdata2, pc: out_pc,
           pc_plus4: out_pc_plus4, dest_pc: out_dest_pc};
    return b;
  endfunction

  initial begin
    // iv ordy fl pc ctrl | e_ov e_pc e_ctrl e_ir
    vecs[0]  = '{1, 1, 0, 16'h0000, CT,   0, 16'h0000, '0,   1};
    vecs[1]  = '{1, 1, 0, 16'h0004, CT,   1, 16'h0000, CT,   1};
    vecs[2]  = '{1, 1, 0, 16'h0008, CT,   1, 16'h0004, CT,   1};
    vecs[3]  = '{0, 1, 0, 16'h0000, CT,   1, 16'h0008, CT,   1};
    vecs[4]  = '{1, 0, 0, 16'h0010, CT,   0, 16'h0000, '0,   1};
    vecs[5]  = '{1, 0, 0, 16'h0014, CT,   1, 16'h0010, CT,   1};
    vecs[6]  = '{1, 0, 0, 16'h0018, CT,   1, 16'h0010, CT,   0};
    vecs[7]  = '{0, 1, 0, 16'h0000, CT,   1, 16'h0010, CT,   0};
    vecs[8]  = '{0, 1, 0, 16'h0000, CT,   1, 16'h0014, CT,   1};
    vecs[9]  = '{0, 0, 0, 16'h0000, CT,   0, 16'h0000, '0,   1};
    vecs[10] = '{1, 0, 0, 16'h001C, CT,   0, 16'h0000, '0,   1};
    vecs[11] = '{1, 0, 0, 16'h0024, CT,   1, 16'h001C, CT,   1};
    vecs[12] = '{1, 0, 1, 16'h0020, CT,   1, 16'h001C, CT,   0};
    vecs[13] = '{0, 1, 0, 16'h0000, CT,   0, 16'h0000, '0,   1};
    vecs[14] = '{1, 1, 1, 16'h0028, CT,   0, 16'h0000, '0,   1};
    vecs[15] = '{0, 1, 0, 16'h0000, CT,   0, 16'h0000, '0,   1};
    vecs[16] = '{1, 1, 0, 16'h0030, ONES, 0, 16'h0000, '0,   1};
    vecs[17] = '{0, 1, 0, 16'h0000, CT,   1, 16'h0030, ONES, 1};
    vecs[18] = '{0, 1, 0, 16'h0000, CT,   0, 16'h0000, '0,   1};

    reset = 1'b0;
    drive(0, 0, 0, 16'h0, '0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_bundle", cur_out(), 0);
    check("rst_hazard", hazard_stall, 0);
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].ctrl, 1, 2, 3);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].e_ctrl);
      check($sformatf("vec%0d_hazard", i), hazard_stall, 0);
      if (vecs[i].e_ov) check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
      @(negedge clk);
    end

    // load-use: dependent via rs2
    drive(1, 0, 0, 16'h0040, LOAD, 1, 2, 5);
    #1 check("lu_empty", out_valid, 0);
    @(negedge clk);
    drive(1, 0, 0, 16'h0044, CT, 7, 5, 6);
    #1;
    check("lu_out_pc", out_pc, 16'h0040);
    check("lu_hazard", hazard_stall, HZ_EN);
    check("lu_in_ready", in_ready, !HZ_EN);
    out_ready = 1'b1;
`ifdef ID_EX_HAZARD_DETECT_EN
    #1 check("lu_hazard_fire", hazard_stall, 1);
    @(negedge clk);
    #1;
    check("lu_bubble_valid", out_valid, 0);
    check("lu_bubble_ctrl", out_ctrl, 0);
    check("lu_bubble_hazard", hazard_stall, 0);
    check("lu_bubble_ready", in_ready, 1);
    @(negedge clk);
`else
    @(negedge clk);
`endif
    in_valid = 1'b0;
    #1;
    check("lu_dep_valid", out_valid, 1);
    check("lu_dep_pc", out_pc, 16'h0044);
    @(negedge clk);
    #1 check("lu_drained", out_valid, 0);

    // load to x0 never stalls
    drive(1, 0, 0, 16'h0048, LOAD, 1, 2, 0);
    @(negedge clk);
    drive(1, 0, 0, 16'h004C, CT, 0, 0, 6);
    #1;
    check("lu_x0_hazard", hazard_stall, 0);
    check("lu_x0_in_ready", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1 check("lu_x0_drained", out_valid, 0);

    // asynchronous reset while in SKID
    drive(1, 0, 0, 16'h0050, CT, 1, 2, 3);
    @(negedge clk);
    drive(1, 0, 0, 16'h0054, CT, 1, 2, 3);
    #1 check("ar_full_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ar_skid_ready", in_ready, 0);
    check("ar_skid_pc", out_pc, 16'h0050);
    #2 reset = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_bundle", cur_out(), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 16'h0060, CT, 1, 2, 3);
    #1 check("ar_post_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ar_post_first_valid", out_valid, 1);
    check("ar_post_first_pc", out_pc, 16'h0060);
    @(negedge clk);
    #1 check("ar_post_drained", out_valid, 0);

    // random traffic vs. queue model (size 2 capacity, FIFO order)
    exp_q.delete();
    for (int n = 0; n < 1500; n++) begin
      logic exp_ov, exp_hz, exp_ir, acc, fir;
      @(negedge clk);
      drive_random();
      #1;
      exp_ov = (exp_q.size() > 0);
      exp_hz = 1'b0;
      if (HZ_EN && exp_ov && in_valid && exp_q[0].ctrl[MEMRE_BIT] && exp_q[0].rd != 0 &&
          (in_rs1 == exp_q[0].rd || in_rs2 == exp_q[0].rd))
        exp_hz = 1'b1;
      exp_ir = (exp_q.size() < 2) && !exp_hz;
      check("rnd_out_valid", out_valid, exp_ov);
      check("rnd_in_ready", in_ready, exp_ir);
      check("rnd_hazard", hazard_stall, exp_hz);
      if (exp_ov) check("rnd_bundle", cur_out(), exp_q[0]);
      else        check("rnd_bubble_ctrl", out_ctrl, 0);
      acc = in_valid && exp_ir;
      fir = exp_ov && out_ready;
      if (flush) exp_q.delete();
      else begin
        if (fir) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(cur_in());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
